store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-path counterpart to the immediate/load extender.
- Narrows a 32-bit register value into word, halfword or byte writes with byte enables and lane-replicated data.
- Buffers the accepted stores in a small queue and issues them to data memory over a req/ack handshake.
- Sits between the MEM-stage store decode and the data-memory port. Back-pressures the pipeline through st_ready.

Parameters:
- DEPTH, 2, store queue entries; power of two, minimum 2.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from pipeline.
- st_op  in  2  00 word, 01 half, 10 byte, 11 reserved.
- st_addr  in  AW  byte address.
- st_data  in  32  register value; low bits used for half/byte.
- st_ready  out  1  queue can accept this cycle.
- mem_req  out  1  write request to data memory.
- mem_addr  out  AW  word-aligned address, {st_addr[AW-1:2],2'b00}.
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory accepts the current request this cycle.
- misalign  out  1  one-cycle error pulse.
- bad_addr  out  AW  address of the last rejected store.
- busy  out  1  queue non-empty.

Behaviour:
- Reset (reset=0, asynchronous): queue empty, pointers and count 0.
  - mem_req=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - misalign=0, bad_addr=0, st_ready=1, busy=0.
- Accept:
  - A store is accepted on a rising edge with st_valid=1 and st_ready=1.
  - st_ready = (count != DEPTH). This is combinational from registered count only. There is no bypass: a full queue rejects even when mem_ack dequeues in the same cycle.
- Formatting, applied at accept time:
  - Word: be=1111, wdata=st_data; requires addr[1:0]=00.
  - Half: be=0011 if addr[1]=0, 1100 if addr[1]=1; wdata={2{st_data[15:0]}}; requires addr[0]=0.
  - Byte: be=0001<<addr[1:0]; wdata={4{st_data[7:0]}}; no alignment requirement.
- Errors: a misaligned address or st_op=11 is not enqueued.
  - The edge still consumes the request.
  - misalign=1 for exactly the next cycle; bad_addr <= st_addr on that edge.
  - The queue and mem outputs are unaffected.
- Issue: mem_* outputs are registered and reflect the head entry.
  - An empty queue accepting a store raises mem_req on the following edge (latency 1 cycle).
  - mem_addr, mem_be and mem_wdata stay stable while mem_req=1 and mem_ack=0.
- Completion: mem_ack=1 while mem_req=1 dequeues the head on that edge.
  - If another entry remains, it is presented on that same edge, so mem_req stays 1 with new contents. Back-to-back stores run at 1/cycle.
  - Otherwise mem_req falls to 0 and mem_be goes to 0.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous enqueue and dequeue (not full): count unchanged, order preserved. The head advances while the tail writes.
- Pointers wrap modulo DEPTH.
- Reset mid-transaction discards all queued stores and drops mem_req immediately (asynchronous).

Decomposition:
- Shared package holds:
  - op codes ST_WORD=2'b00, ST_HALF=2'b01, ST_BYTE=2'b10, ST_RSVD=2'b11;
  - the queue entry layout {addr[AW-1:2], be[3:0], wdata[31:0]};
  - BE constants BE_WORD, BE_HLO, BE_HHI.
- One natural combinational sub-module is store_lane_format. Inputs: op, addr[1:0], data. Outputs: be, wdata, err. The queue and handshake stay in store_narrow_unit.

Test Plan:
- Byte stores with mem_ack tied 1:
  - st_op=10, addr=0x1003, data=0xAABBCCDD → next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xDDDDDDDD.
  - A second byte at 0x1001 issues the following cycle with be=0010.
- Half store: st_op=01, addr=0x2002, data=0x12345678 → mem_be=1100, mem_wdata=0x56785678, mem_addr=0x2000.
- Misaligned/reserved stores:
  - st_op=00, addr=0x3001 → misalign pulses 1 cycle, bad_addr=0x3001, mem_req stays 0, st_ready stays 1.
  - st_op=11, addr=0x3000 → same error response.
- Full queue with mem_ack=0, DEPTH=2:
  - Two word stores accepted; st_ready=0; a third st_valid is held off.
  - Hold mem_ack=0 for 5 cycles → mem_* outputs unchanged.
  - Pulse mem_ack → second store presented the same edge; st_ready=1 next cycle.
- Simultaneous accept and ack with count=1: count stays 1, and stores issue in acceptance order (check addresses 0x10, 0x14, 0x18).
- Assert reset low while mem_req=1 with 2 entries queued → mem_req=0 with no clock edge; after release, busy=0 and st_ready=1.

Source files
------------

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store narrowing path: op codes, byte-enable
// patterns and the lane portion of a queued store entry.
package store_narrow_unit_pkg;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;
  localparam logic [1:0] ST_RSVD = 2'b11;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;

  // Lane part of a queue entry; the word address is prepended by the
  // queue owner, giving {addr[AW-1:2], be[3:0], wdata[31:0]}.
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_lane_t;

endpackage

// File: rtl/store_narrow_unit_lane_format.sv
// Combinational store formatter: byte enables, lane-replicated write data
// and an alignment/op error flag for one store.
module store_lane_format
  import store_narrow_unit_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        err
);

  // Select enables and replicate the narrow value into every lane it may hit
  always_comb begin
    be    = BE_NONE;
    wdata = '0;
    err   = 1'b0;
    case (op)
      ST_WORD: begin
        be    = BE_WORD;
        wdata = data;
        err   = (addr != 2'b00);
      end
      ST_HALF: begin
        be    = addr[1] ? BE_HHI : BE_HLO;
        wdata = {2{data[15:0]}};
        err   = addr[0];
      end
      ST_BYTE: begin
        be    = 4'b0001 << addr;
        wdata = {4{data[7:0]}};
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: formats accepted stores, buffers them in a small
// FIFO and presents the head entry to data memory over a req/ack handshake.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          misalign,
  output logic [AW-1:0] bad_addr,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-3:0] waddr;
    st_lane_t      lane;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [3:0]    fmt_be;
  logic [31:0]   fmt_wdata;
  logic          fmt_err;

  logic          take;
  logic          enq;
  logic          deq;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] remain;
  logic [PW-1:0] rd_ptr_nxt;
  entry_t        new_entry;
  entry_t        head_nxt;

  store_lane_format u_fmt (
    .op    (st_op),
    .addr  (st_addr[1:0]),
    .data  (st_data),
    .be    (fmt_be),
    .wdata (fmt_wdata),
    .err   (fmt_err)
  );

  // No bypass: readiness depends on the registered occupancy only
  assign st_ready   = (count != CW'(DEPTH));
  assign busy       = (count != '0);
  assign take       = st_valid && st_ready;
  assign enq        = take && !fmt_err;
  assign deq        = mem_req && mem_ack;
  assign count_nxt  = count + CW'(enq) - CW'(deq);
  assign remain     = count - CW'(deq);
  assign rd_ptr_nxt = rd_ptr + PW'(deq);
  assign new_entry  = '{waddr: st_addr[AW-1:2], lane: '{be: fmt_be, wdata: fmt_wdata}};

  // Head after this edge: the incoming store when nothing older survives
  always_comb begin
    head_nxt = q[rd_ptr_nxt];
    if (remain == '0) head_nxt = new_entry;
  end

  // Queue storage carries no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= new_entry;
  end

  // Queue control, registered memory interface and error reporting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= BE_NONE;
      mem_wdata <= '0;
      misalign  <= 1'b0;
      bad_addr  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) begin
        mem_req   <= 1'b1;
        mem_addr  <= {head_nxt.waddr, 2'b00};
        mem_be    <= head_nxt.lane.be;
        mem_wdata <= head_nxt.lane.wdata;
      end else begin
        mem_req <= 1'b0;
        mem_be  <= BE_NONE;
      end
      misalign <= take && fmt_err;
      if (take && fmt_err) bad_addr <= st_addr;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit with hand-computed expectations.
module tb_store_narrow_unit;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        misalign;
  logic [31:0] bad_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  store_narrow_unit #(.DEPTH(2), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .misalign  (misalign),
    .bad_addr  (bad_addr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ack = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b0, 32'h0, 4'b0000, 32'h0}) begin
      errors++;
      $display("FAIL reset_mem got req=%b addr=%h be=%b wd=%h want 0", mem_req, mem_addr, mem_be, mem_wdata);
    end
    checks++;
    if ({misalign, bad_addr, st_ready, busy} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctl got mis=%b bad=%h rdy=%b busy=%b want 0 0 1 0", misalign, bad_addr, st_ready, busy);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_byte();
    mem_ack = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_1003, 32'hAABB_CCDD);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hDDDD_DDDD}) begin
      errors++;
      $display("FAIL byte0 got req=%b addr=%h be=%b wd=%h want 1 1000 1000 dddddddd", mem_req, mem_addr, mem_be, mem_wdata);
    end
    drive(1'b1, 2'b10, 32'h0000_1001, 32'hAABB_CCDD);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h1000, 4'b0010, 32'hDDDD_DDDD}) begin
      errors++;
      $display("FAIL byte1 got req=%b addr=%h be=%b wd=%h want 1 1000 0010 dddddddd", mem_req, mem_addr, mem_be, mem_wdata);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++;
    if ({mem_req, mem_be, busy} !== {1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL byte_drain got req=%b be=%b busy=%b want 0 0000 0", mem_req, mem_be, busy);
    end
  endtask

  task automatic test_half();
    mem_ack = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_2002, 32'h1234_5678);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'h5678_5678}) begin
      errors++;
      $display("FAIL half got req=%b addr=%h be=%b wd=%h want 1 2000 1100 56785678", mem_req, mem_addr, mem_be, mem_wdata);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL half_drain got req=%b want 0", mem_req);
    end
  endtask

  task automatic test_misalign();
    mem_ack = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_3001, 32'hFFFF_FFFF);
    step();
    checks++;
    if ({misalign, bad_addr, mem_req, st_ready, busy} !== {1'b1, 32'h3001, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mis_word got mis=%b bad=%h req=%b rdy=%b busy=%b want 1 3001 0 1 0", misalign, bad_addr, mem_req, st_ready, busy);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++;
    if ({misalign, bad_addr} !== {1'b0, 32'h3001}) begin
      errors++;
      $display("FAIL mis_pulse got mis=%b bad=%h want 0 3001", misalign, bad_addr);
    end
    drive(1'b1, 2'b11, 32'h0000_3000, 32'h1);
    step();
    checks++;
    if ({misalign, bad_addr, mem_req, st_ready} !== {1'b1, 32'h3000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mis_rsvd got mis=%b bad=%h req=%b rdy=%b want 1 3000 0 1", misalign, bad_addr, mem_req, st_ready);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++;
    if ({misalign, mem_req, busy} !== {1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mis_end got mis=%b req=%b busy=%b want 0 0 0", misalign, mem_req, busy);
    end
  endtask

  task automatic test_full();
    mem_ack = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0040, 32'h1111_1111);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_wdata, st_ready} !== {1'b1, 32'h40, 32'h1111_1111, 1'b1}) begin
      errors++;
      $display("FAIL full_first got req=%b addr=%h wd=%h rdy=%b want 1 40 11111111 1", mem_req, mem_addr, mem_wdata, st_ready);
    end
    drive(1'b1, 2'b00, 32'h0000_0044, 32'h2222_2222);
    step();
    checks++;
    if ({st_ready, mem_addr} !== {1'b0, 32'h40}) begin
      errors++;
      $display("FAIL full_ready got rdy=%b addr=%h want 0 40", st_ready, mem_addr);
    end
    drive(1'b1, 2'b00, 32'h0000_0048, 32'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({mem_req, mem_addr, mem_be, mem_wdata, st_ready} !== {1'b1, 32'h40, 4'b1111, 32'h1111_1111, 1'b0}) begin
        errors++;
        $display("FAIL full_hold%0d got req=%b addr=%h be=%b wd=%h rdy=%b want 1 40 1111 11111111 0", i, mem_req, mem_addr, mem_be, mem_wdata, st_ready);
      end
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, st_ready} !== {1'b1, 32'h44, 32'h2222_2222, 1'b1}) begin
      errors++;
      $display("FAIL full_ack got req=%b addr=%h wd=%h rdy=%b want 1 44 22222222 1", mem_req, mem_addr, mem_wdata, st_ready);
    end
    step();
    checks++;
    if ({st_ready, mem_addr} !== {1'b0, 32'h44}) begin
      errors++;
      $display("FAIL full_third got rdy=%b addr=%h want 0 44", st_ready, mem_addr);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    mem_ack = 1'b1;
    step();
    checks++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h48, 32'h3333_3333}) begin
      errors++;
      $display("FAIL full_last got req=%b addr=%h wd=%h want 1 48 33333333", mem_req, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({mem_req, busy, st_ready} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_drain got req=%b busy=%b rdy=%b want 0 0 1", mem_req, busy, st_ready);
    end
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0010, 32'hA0);
    step();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL b2b_0 got req=%b addr=%h want 1 10", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    drive(1'b1, 2'b00, 32'h0000_0014, 32'hA4);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_wdata, st_ready, busy} !== {1'b1, 32'h14, 32'hA4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_1 got req=%b addr=%h wd=%h rdy=%b busy=%b want 1 14 a4 1 1", mem_req, mem_addr, mem_wdata, st_ready, busy);
    end
    drive(1'b1, 2'b00, 32'h0000_0018, 32'hA8);
    step();
    checks++;
    if ({mem_req, mem_addr, mem_wdata, st_ready} !== {1'b1, 32'h18, 32'hA8, 1'b1}) begin
      errors++;
      $display("FAIL b2b_2 got req=%b addr=%h wd=%h rdy=%b want 1 18 a8 1", mem_req, mem_addr, mem_wdata, st_ready);
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++;
    if ({mem_req, busy} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_drain got req=%b busy=%b want 0 0", mem_req, busy);
    end
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0020, 32'h5);
    step();
    drive(1'b1, 2'b00, 32'h0000_0024, 32'h6);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    checks++;
    if ({mem_req, st_ready} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_pre got req=%b rdy=%b want 1 0", mem_req, st_ready);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_be, busy, st_ready} !== {1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async got req=%b be=%b busy=%b rdy=%b want 0 0000 0 1", mem_req, mem_be, busy, st_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if ({mem_req, busy, st_ready} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_post got req=%b busy=%b rdy=%b want 0 0 1", mem_req, busy, st_ready);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
